// File: rtl/ac_pkg.sv
// Shared definitions for the serial receiver: output-register state
// encoding and a ceiling-log2 helper used to size the bit counter.
package ac_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_st_t;

    // ceil(log2(n)), never less than 1 so a counter always has a bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input and parallel output handshake bundle for sipo_rx.
// The par_err wire only exists when SIPO_RX_PARITY_EN is defined.
interface sipo_rx_if #(parameter int w = 4);

    logic         sin;
    logic         sin_vld;
    logic [w-1:0] data_out;
    logic         out_vld;
    logic         out_rdy;
    logic         ovr;
`ifdef SIPO_RX_PARITY_EN
    logic         par_err;
`endif

`ifdef SIPO_RX_PARITY_EN
    modport master (output sin, sin_vld, out_rdy,
                    input  data_out, out_vld, ovr, par_err);
    modport slave  (input  sin, sin_vld, out_rdy,
                    output data_out, out_vld, ovr, par_err);
`else
    modport master (output sin, sin_vld, out_rdy,
                    input  data_out, out_vld, ovr);
    modport slave  (input  sin, sin_vld, out_rdy,
                    output data_out, out_vld, ovr);
`endif

endinterface

// File: rtl/sipo_shreg.sv
// w-bit right-shift register: new bits enter at the MSB so the first
// bit received ends up in bit 0 after w shifts.
module sipo_shreg #(
    parameter int           w       = 4,
    parameter logic [w-1:0] rst_val = '0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_din,
    output logic [w-1:0] o_q
);

    logic [w-1:0] r_q;

    // shift right on enable; clear returns to the reset pattern
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_q <= rst_val;
        end else if (i_clr) begin
            r_q <= rst_val;
        end else if (i_en) begin
            r_q <= {i_din, r_q[w-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver, LSB first, with a one-deep output
// register (valid/ready) and a sticky overrun flag.
// Optional: define SIPO_RX_PARITY_EN for w data bits + one even-parity
// bit per frame and a par_err output loaded alongside data_out.
//
// state    | meaning
// ST_EMPTY | output register holds no unconsumed word (out_vld = 0)
// ST_FULL  | output register holds a word awaiting out_rdy (out_vld = 1)
module sipo_rx
    import ac_pkg::*;
#(
    parameter int           w       = 4,
    parameter logic [w-1:0] rst_val = '0
) (
    input  logic     clk,
    input  logic     rst_b,
    input  logic     clr,
    sipo_rx_if.slave bus
);

`ifdef SIPO_RX_PARITY_EN
    localparam int           CW   = clog2(w + 1);
    localparam logic [CW-1:0] LAST = CW'(w);
`else
    localparam int           CW   = clog2(w);
    localparam logic [CW-1:0] LAST = CW'(w - 1);
`endif

    logic [CW-1:0] r_cnt;
    logic [w-1:0]  r_data;
    logic          r_ovr;
    out_st_t       r_state;
    out_st_t       w_state_nxt;
    logic          w_load;
    logic          w_set_ovr;
    logic          w_done;
    logic          w_shift;
    logic [w-1:0]  w_shreg;
    logic [w-1:0]  w_word;

`ifdef SIPO_RX_PARITY_EN
    logic          r_par_err;
    logic          w_par_err;

    // the parity bit completes the frame but is never shifted in
    assign w_shift   = bus.sin_vld && (r_cnt != LAST);
    assign w_word    = w_shreg;
    assign w_par_err = (^w_shreg) ^ bus.sin;
`else
    logic          w_unused_lsb;

    // the completing bit is folded in directly, so shreg bit 0 is
    // already shifted out by the time the word is assembled
    assign w_shift      = bus.sin_vld;
    assign w_word       = {bus.sin, w_shreg[w-1:1]};
    assign w_unused_lsb = w_shreg[0];
`endif

    assign w_done = bus.sin_vld && (r_cnt == LAST);

    sipo_shreg #(.w(w), .rst_val(rst_val)) u_shreg (
        .clk   (clk),
        .rst_b (rst_b),
        .i_clr (clr),
        .i_en  (w_shift),
        .i_din (bus.sin),
        .o_q   (w_shreg)
    );

    // bit counter, wraps at frame end; held while sin_vld is low
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (bus.sin_vld) begin
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        end
    end

    // output FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_EMPTY;
        end else if (clr) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state, load strobe and overrun detection
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_done && bus.out_rdy) begin
                    w_load = 1'b1;
                end else if (w_done) begin
                    w_set_ovr = 1'b1;
                end else if (bus.out_rdy) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // output data register; clr leaves the last word visible
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_data <= rst_val;
        end else if (!clr && w_load) begin
            r_data <= w_word;
        end
    end

`ifdef SIPO_RX_PARITY_EN
    // parity flag travels with its word
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_par_err <= 1'b0;
        end else if (!clr && w_load) begin
            r_par_err <= w_par_err;
        end
    end

    assign bus.par_err = r_par_err;
`endif

    // sticky overrun flag
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ovr <= 1'b0;
        end else if (clr) begin
            r_ovr <= 1'b0;
        end else if (w_set_ovr) begin
            r_ovr <= 1'b1;
        end
    end

    assign bus.data_out = r_data;
    assign bus.out_vld  = (r_state == ST_FULL);
    assign bus.ovr      = r_ovr;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (w = 4, rst_val = 0). Consumed words are
// checked by a scoreboard monitor; flags and held values are checked inline.
module tb_sipo_rx;

    localparam int W = 4;

    logic clk;
    logic rst_b;
    logic clr;

    int n_tests;
    int n_fail;

    logic [W-1:0] sb_q[$];

    sipo_rx_if #(.w(W)) bus ();

    sipo_rx #(.w(W), .rst_val(4'b0000)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // consumer side: every handshake must deliver the next queued word
    always @(negedge clk) begin
        if (rst_b && bus.out_vld && bus.out_rdy) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected no word", bus.data_out);
            end else begin
                check("sb_word", 32'(bus.data_out), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.sin     = b;
        bus.sin_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.sin_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one frame; rdy_last drives out_rdy only on the completing edge
    task automatic send_word(input logic [W-1:0] d, input int gap, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
`ifndef SIPO_RX_PARITY_EN
            if (i == W - 1) bus.out_rdy = rdy_last;
`endif
            send_bit(d[i]);
            if (gap > 0 && i < W - 1) idle(gap);
        end
`ifdef SIPO_RX_PARITY_EN
        bus.out_rdy = rdy_last;
        send_bit(^d);
`endif
        bus.out_rdy = 1'b0;
    endtask

    task automatic drain();
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_b       = 1'b1;
        clr         = 1'b0;
        bus.sin     = 1'b0;
        bus.sin_vld = 1'b0;
        bus.out_rdy = 1'b0;

        // asynchronous reset before any clock edge
        #2 rst_b = 1'b0;
        #1;
        check("rst_data", 32'(bus.data_out), 32'h0);
        check("rst_vld", 32'(bus.out_vld), 32'h0);
        check("rst_ovr", 32'(bus.ovr), 32'h0);
        #24 rst_b = 1'b1;
        @(posedge clk);
        #1;

        // out_rdy while empty is ignored
        drain();
        check("empty_rdy_vld", 32'(bus.out_vld), 32'h0);

        // basic word 0,1,0,1
        send_word(4'b1010, 0, 1'b0);
        check("basic_vld", 32'(bus.out_vld), 32'h1);
        check("basic_data", 32'(bus.data_out), 32'hA);
        sb_q.push_back(4'b1010);
        drain();
        check("basic_pop_vld", 32'(bus.out_vld), 32'h0);
        check("basic_hold_data", 32'(bus.data_out), 32'hA);

        // same-edge accept and reload
        send_word(4'b1010, 0, 1'b0);
        sb_q.push_back(4'b1010);
        send_word(4'b0011, 0, 1'b1);
        check("b2b_vld", 32'(bus.out_vld), 32'h1);
        check("b2b_data", 32'(bus.data_out), 32'h3);
        check("b2b_ovr", 32'(bus.ovr), 32'h0);
        sb_q.push_back(4'b0011);
        drain();
        check("b2b_pop_vld", 32'(bus.out_vld), 32'h0);

        // overrun drops the new word
        send_word(4'b1010, 0, 1'b0);
        send_word(4'b1111, 0, 1'b0);
        check("ovr_data", 32'(bus.data_out), 32'hA);
        check("ovr_vld", 32'(bus.out_vld), 32'h1);
        check("ovr_flag", 32'(bus.ovr), 32'h1);
        idle(2);
        check("ovr_sticky", 32'(bus.ovr), 32'h1);
        pulse_clr();
        check("clr_vld", 32'(bus.out_vld), 32'h0);
        check("clr_ovr", 32'(bus.ovr), 32'h0);
        check("clr_data_hold", 32'(bus.data_out), 32'hA);

        // gaps between bits
        send_word(4'b1101, 3, 1'b0);
        check("gap_data", 32'(bus.data_out), 32'hD);
        sb_q.push_back(4'b1101);
        drain();

        // partial word discarded by clr
        send_bit(1'b1);
        idle(3);
        send_bit(1'b0);
        pulse_clr();
        check("midclr_vld", 32'(bus.out_vld), 32'h0);
        send_word(4'b0111, 0, 1'b0);
        check("midclr_data", 32'(bus.data_out), 32'h7);
        check("midclr_vld2", 32'(bus.out_vld), 32'h1);
        sb_q.push_back(4'b0111);
        drain();

        // partial word discarded by reset
        send_bit(1'b1);
        send_bit(1'b1);
        #2 rst_b = 1'b0;
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;
        send_word(4'b0100, 0, 1'b0);
        check("midrst_data", 32'(bus.data_out), 32'h4);
        sb_q.push_back(4'b0100);
        drain();

`ifdef SIPO_RX_PARITY_EN
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("par_err", 32'(bus.par_err), 32'h1);
        check("par_data", 32'(bus.data_out), 32'h5);
        sb_q.push_back(4'b0101);
        drain();
        send_word(4'b0110, 0, 1'b0);
        check("par_ok", 32'(bus.par_err), 32'h0);
        sb_q.push_back(4'b0110);
        drain();
`endif

        idle(2);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
